// File: rtl/program_loader_if.sv
// Byte stream in from the serial receiver, word writes out to program memory.
interface program_loader_if #(
   parameter int AB = 11,
   parameter int DB = 16
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          wr_en;
   logic [AB-1:0] wr_addr;
   logic [DB-1:0] wr_data;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/program_loader.sv
// Packs received bytes (high first) into 16-bit words written to program memory from address 0;
// one write per 3 cycles at best, rx_ready low during the write cycle and outside a session.
module program_loader #(
   parameter int AB = 11,
   parameter int DB = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   program_loader_if.master bus,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [AB:0]      word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [AB-1:0] ADDR_LAST = {AB{1'b1}};

   state_t        state_q, state_d;
   logic [AB-1:0] addr_q, addr_d;
   logic [7:0]    hi_q, hi_d;
   logic [AB-1:0] wr_addr_q, wr_addr_d;
   logic [DB-1:0] wr_data_q, wr_data_d;
   logic [AB:0]   word_count_q, word_count_d;
   logic          overflow_q, overflow_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         hi_q         <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         hi_q         <= hi_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      hi_d         = hi_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               addr_d       = '0;
               word_count_d = '0;
               overflow_d   = 1'b0;
               state_d      = S_HI;
            end
         end
         S_HI: begin
            if (bus.rx_valid) begin
               hi_d    = bus.rx_data;
               state_d = S_LO;
            end
         end
         S_LO: begin
            // Write bus is loaded here so it is registered and stable through the WR cycle.
            if (bus.rx_valid) begin
               wr_addr_d = addr_q;
               wr_data_d = {hi_q, bus.rx_data};
               state_d   = S_WR;
            end
         end
         S_WR: begin
            word_count_d = word_count_q + (AB+1)'(1);
            if (wr_data_q == '0) begin
               state_d = S_DONE;
            end else if (addr_q == ADDR_LAST) begin
               overflow_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               addr_d  = addr_q + AB'(1);
               state_d = S_HI;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rx_ready = (state_q == S_HI) || (state_q == S_LO);
   assign bus.wr_en    = (state_q == S_WR);
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign busy         = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WR);
   assign done         = (state_q == S_DONE);
   assign overflow     = overflow_q;
   assign word_count   = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: drives byte streams and checks memory writes against a word-list model.
module tb_program_loader;
   localparam int AB = 11;
   localparam int DB = 16;
   localparam int NW = 1 << AB;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [AB:0] word_count;

   program_loader_if #(.AB(AB), .DB(DB)) bus ();

   program_loader #(.AB(AB), .DB(DB)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int rdy_in_wr = 0;

   int          obs_addr[$];
   logic [15:0] obs_data[$];
   int          obs_cyc[$];
   logic [7:0]  sent[$];
   int          exp_addr[$];
   logic [15:0] exp_data[$];
   bit          exp_ovf;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         obs_addr.push_back(int'(bus.wr_addr));
         obs_data.push_back(bus.wr_data);
         obs_cyc.push_back(cyc);
         if (bus.rx_ready !== 1'b0) rdy_in_wr++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time exhausted, required the bench to finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_session();
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); sent.delete();
   endtask

   task automatic idle(input int n);
      bus.rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      bus.rx_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Presents a byte until the loader takes it; gives up after 8 cycles.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (bus.rx_ready === 1'b1) ok = 1'b1;
         @(negedge clk);
      end
      if (ok) sent.push_back(b);
   endtask

   task automatic send_word(input logic [15:0] w, input int maxgap, inout int lost);
      bit ok;
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send_byte(w[15:8], ok);
      if (!ok) lost++;
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send_byte(w[7:0], ok);
      if (!ok) lost++;
   endtask

   task automatic wait_done(output bit ok);
      bus.rx_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (done === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   function automatic logic [15:0] rnd_word();
      return 16'($urandom_range(1, 65535));
   endfunction

   // Reference: pair accepted bytes into words; stop at HALT or after the last address.
   task automatic build_expect();
      logic [15:0] w;
      exp_addr.delete(); exp_data.delete(); exp_ovf = 1'b0;
      for (int k = 0; 2*k+1 < sent.size(); k++) begin
         w = {sent[2*k], sent[2*k+1]};
         exp_addr.push_back(k);
         exp_data.push_back(w);
         if (w == 16'h0000) break;
         if (k == NW-1) begin
            exp_ovf = 1'b1;
            break;
         end
      end
   endtask

   function automatic int write_diffs();
      int d = 0;
      if (obs_addr.size() != exp_addr.size()) return -1;
      foreach (exp_addr[i])
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) d++;
      return d;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.wr_en, bus.rx_ready, busy, done, overflow} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got wr_en/rx_ready/busy/done/overflow=%b, need 00000",
                  {bus.wr_en, bus.rx_ready, busy, done, overflow});
      end
      n_cmp++;
      if (word_count !== '0) begin
         n_bad++; $display("FAIL reset_word_count: got %0d, need 0", word_count);
      end
      n_cmp++;
      if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
         n_bad++; $display("FAIL reset_wr_bus: got addr %0d data %h, need 0/0000", bus.wr_addr, bus.wr_data);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_idle_rx();
      int  rdy_bad = 0;
      int  lost = 0;
      bit  ok;
      logic [15:0] w;
      clear_session();
      for (int i = 0; i < 6; i++) begin
         bus.rx_valid = 1'($urandom_range(0, 1));
         bus.rx_data  = 8'($urandom);
         @(negedge clk);
         if (bus.rx_ready !== 1'b0) rdy_bad++;
      end
      n_cmp++;
      if (rdy_bad != 0 || obs_addr.size() != 0) begin
         n_bad++;
         $display("FAIL idle_rx_ignored: got %0d rx_ready cycles and %0d writes, need 0 and 0", rdy_bad, obs_addr.size());
      end
      pulse_start();
      w = rnd_word();
      send_word(w, 0, lost);
      send_word(16'h0000, 0, lost);
      wait_done(ok);
      n_cmp++;
      if (!ok || lost != 0 || obs_addr.size() == 0 || obs_addr[0] != 0 || obs_data[0] !== w) begin
         n_bad++;
         $display("FAIL idle_rx_first_word: got %0d writes first data %h done_ok=%0d lost=%0d, need addr 0 data %h",
                  obs_addr.size(), (obs_data.size() > 0) ? obs_data[0] : 16'hxxxx, ok, lost, w);
      end
   endtask

   task automatic test_basic();
      int lost = 0;
      bit ok;
      clear_session();
      pulse_start();
      send_word(16'h0801, 0, lost);
      send_word(16'h0000, 0, lost);
      wait_done(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL basic_done: done never rose, need done=1"); end
      n_cmp++;
      if (obs_addr.size() != 2 || obs_addr[0] != 0 || obs_data[0] !== 16'h0801 ||
          obs_addr[1] != 1 || obs_data[1] !== 16'h0000) begin
         n_bad++;
         $display("FAIL basic_writes: got %0d writes, need (0,0801),(1,0000)", obs_addr.size());
      end
      n_cmp++;
      if ({done, overflow, busy} !== 3'b100 || word_count !== (AB+1)'(2)) begin
         n_bad++;
         $display("FAIL basic_status: got done/ovf/busy=%b count=%0d, need 100 and 2", {done, overflow, busy}, word_count);
      end
   endtask

   task automatic test_back_to_back();
      int lost = 0;
      int gap_bad = 0;
      int d;
      bit ok;
      clear_session();
      pulse_start();
      for (int i = 0; i < 6; i++) send_word(rnd_word(), 0, lost);
      send_word(16'h0000, 0, lost);
      wait_done(ok);
      build_expect();
      for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] - obs_cyc[i-1] != 3) gap_bad++;
      n_cmp++;
      if (gap_bad != 0 || obs_cyc.size() != 7) begin
         n_bad++; $display("FAIL b2b_spacing: got %0d writes with %0d non-3-cycle gaps, need 7 and 0", obs_cyc.size(), gap_bad);
      end
      n_cmp++;
      if (rdy_in_wr != 0) begin
         n_bad++; $display("FAIL b2b_ready_in_wr: got %0d cycles with rx_ready in WR, need 0", rdy_in_wr);
      end
      d = write_diffs();
      n_cmp++;
      if (!ok || lost != 0 || d != 0) begin
         n_bad++; $display("FAIL b2b_writes: got diffs=%0d lost=%0d done_ok=%0d, need 0/0/1", d, lost, ok);
      end
   endtask

   task automatic test_random();
      int lost;
      int d;
      int nw;
      bit ok;
      for (int s = 0; s < 4; s++) begin
         clear_session();
         lost = 0;
         idle($urandom_range(0, 4));
         pulse_start();
         nw = $urandom_range(1, 20);
         for (int i = 0; i < nw; i++) send_word(rnd_word(), 3, lost);
         send_word(16'h0000, 3, lost);
         wait_done(ok);
         build_expect();
         d = write_diffs();
         n_cmp++;
         if (!ok || lost != 0 || d != 0) begin
            n_bad++; $display("FAIL random_writes[%0d]: got diffs=%0d lost=%0d done_ok=%0d, need 0/0/1", s, d, lost, ok);
         end
         n_cmp++;
         if (word_count !== (AB+1)'(exp_addr.size()) || overflow !== exp_ovf) begin
            n_bad++;
            $display("FAIL random_status[%0d]: got count=%0d ovf=%b, need %0d/%b", s, word_count, overflow, exp_addr.size(), exp_ovf);
         end
      end
   endtask

   task automatic test_start_lo();
      int lost = 0;
      int d;
      bit ok;
      clear_session();
      pulse_start();
      send_word(rnd_word(), 0, lost);
      send_byte(8'($urandom), ok);
      if (!ok) lost++;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
         n_bad++; $display("FAIL start_in_lo_state: got busy=%b rx_ready=%b, need 1/1", busy, bus.rx_ready);
      end
      send_byte(8'($urandom_range(1, 255)), ok);
      if (!ok) lost++;
      send_word(16'h0000, 0, lost);
      wait_done(ok);
      build_expect();
      d = write_diffs();
      n_cmp++;
      if (!ok || lost != 0 || d != 0 || obs_addr.size() != 3) begin
         n_bad++; $display("FAIL start_in_lo_writes: got diffs=%0d writes=%0d lost=%0d, need 0/3/0", d, obs_addr.size(), lost);
      end
      clear_session();
      pulse_start();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1 || word_count !== '0) begin
         n_bad++; $display("FAIL start_in_done: got done=%b busy=%b count=%0d, need 0/1/0", done, busy, word_count);
      end
      send_word(rnd_word(), 1, lost);
      send_word(16'h0000, 1, lost);
      wait_done(ok);
      build_expect();
      d = write_diffs();
      n_cmp++;
      if (!ok || lost != 0 || d != 0) begin
         n_bad++; $display("FAIL restart_writes: got diffs=%0d lost=%0d done_ok=%0d, need 0/0/1", d, lost, ok);
      end
   endtask

   task automatic test_reset_mid();
      int lost = 0;
      int d;
      bit ok;
      logic [15:0] w;
      clear_session();
      pulse_start();
      send_word(rnd_word(), 0, lost);
      send_byte(8'($urandom), ok);
      reset = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({bus.wr_en, bus.rx_ready, busy, done, overflow} !== 5'b0 || word_count !== '0 ||
          bus.wr_addr !== '0 || bus.wr_data !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_outputs: got flags=%b count=%0d addr=%0d data=%h, need all 0",
                  {bus.wr_en, bus.rx_ready, busy, done, overflow}, word_count, bus.wr_addr, bus.wr_data);
      end
      reset = 1'b0;
      idle(4);
      n_cmp++;
      if (obs_addr.size() != 1 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_no_write: got %0d writes busy=%b done=%b, need 1/0/0", obs_addr.size(), busy, done);
      end
      clear_session();
      pulse_start();
      w = rnd_word();
      send_word(w, 2, lost);
      send_word(16'h0000, 2, lost);
      wait_done(ok);
      build_expect();
      d = write_diffs();
      n_cmp++;
      if (!ok || lost != 0 || d != 0 || obs_data.size() == 0 || obs_data[0] !== w) begin
         n_bad++; $display("FAIL reset_mid_restart: got diffs=%0d lost=%0d, need 0/0 with first word %h at addr 0", d, lost, w);
      end
   endtask

   task automatic test_overflow();
      int lost = 0;
      int d;
      int nw_before;
      bit ok;
      clear_session();
      pulse_start();
      for (int i = 0; i < NW; i++) send_word(rnd_word(), 0, lost);
      wait_done(ok);
      build_expect();
      d = write_diffs();
      n_cmp++;
      if (!ok || lost != 0 || d != 0 || obs_addr.size() != NW || obs_addr[NW-1] != NW-1) begin
         n_bad++; $display("FAIL overflow_writes: got diffs=%0d writes=%0d lost=%0d, need 0/%0d/0", d, obs_addr.size(), lost, NW);
      end
      n_cmp++;
      if (overflow !== 1'b1 || exp_ovf !== 1'b1 || word_count !== (AB+1)'(NW) || done !== 1'b1) begin
         n_bad++; $display("FAIL overflow_status: got ovf=%b count=%0d done=%b, need 1/%0d/1", overflow, word_count, done, NW);
      end
      nw_before = obs_addr.size();
      send_byte(8'h5A, ok);
      send_byte(8'hA5, ok);
      idle(3);
      n_cmp++;
      if (ok || obs_addr.size() != nw_before) begin
         n_bad++; $display("FAIL overflow_extra: got accepted=%0d writes=%0d, need 0/%0d", ok, obs_addr.size(), nw_before);
      end
   endtask

   initial begin
      start = 1'b0;
      reset = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_idle_rx();
      test_basic();
      test_back_to_back();
      test_random();
      test_start_lo();
      test_reset_mid();
      test_overflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU program memory: receives a byte stream from the serial receiver and assembles 16-bit instruction words, high byte first.
- Writes each word sequentially into program memory starting at address 0.
- Stops after writing the HALT word (16'h0000) or after filling the address space; `done` then releases the CPU to fetch.

Parameters:
AB  11  program memory address width (2^AB words)
DB  16  instruction word width; fixed at 16 (two bytes per word), other values unsupported

Ports:
clk         in   1       system clock, all logic on rising edge
reset       in   1       synchronous, active-high reset
start       in   1       one-cycle pulse; begins a load session
rx_data     in   8       byte from serial receiver
rx_valid    in   1       rx_data valid this cycle
rx_ready    out  1       loader accepts a byte this cycle (byte taken when rx_valid & rx_ready)
wr_en       out  1       program memory write strobe, one cycle per word
wr_addr     out  AB      program memory write address
wr_data     out  DB      program memory write data {hi_byte, lo_byte}
busy        out  1       load session in progress
done        out  1       load finished; held until next start or reset
overflow    out  1       session ended by address-space exhaustion without HALT; valid while done=1
word_count  out  AB+1    number of words written in current/last session

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0, including wr_en, rx_ready, busy, done, overflow and word_count. Reset mid-session aborts immediately; no further wr_en after the reset edge, and captured bytes are discarded.
- States: IDLE, HI, LO, WR, DONE.
- IDLE: rx_ready=0; rx_valid ignored. On start: addr<=0, word_count<=0, overflow<=0, busy<=1 -> HI.
- HI: rx_ready=1. On rx_valid: hi_byte<=rx_data -> LO.
- LO: rx_ready=1. On rx_valid: lo_byte<=rx_data -> WR.
- WR: rx_ready=0; wr_en=1 for exactly this cycle, with wr_addr=addr and wr_data={hi_byte,lo_byte}; word_count<=word_count+1.
  - If wr_data==16'h0000 (HALT): -> DONE with overflow=0. The HALT word itself is written.
  - Else if addr==2^AB-1: -> DONE with overflow=1; addr does not wrap.
  - Else addr<=addr+1 -> HI.
- DONE: busy=0, done=1, rx_ready=0; overflow and word_count held. On start: clear done/overflow/word_count, addr<=0 -> HI (new session).
- Latency: wr_en is asserted in the cycle after the low byte is accepted; minimum 3 cycles per word when bytes arrive back-to-back.
- start while in HI/LO/WR: ignored, with no restart and no effect on addr.
- rx_valid in IDLE/WR/DONE: byte not consumed (rx_ready=0); the upstream source must hold or drop it, and the loader never stalls on it.
- wr_addr and wr_data are driven as registered values; outside WR they hold their last values and are qualified only by wr_en.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset, start, bytes 08 01 00 00 -> wr_en at addr 0 data 16'h0801, then addr 1 data 16'h0000; done=1, overflow=0, word_count=2, busy=0.
- Bytes arriving back-to-back, one per cycle (rx_valid held high) -> exactly one wr_en every 3 cycles; rx_ready low in the WR cycle; no byte lost or duplicated; addresses 0,1,2,... in order.
- AB=3, eight nonzero words 0001..0008 -> writes at addr 0..7; after the addr 7 write done=1, overflow=1, word_count=8, no 9th write; further rx_valid bytes not accepted.
- Reset asserted after the high byte of word 2 -> no wr_en follows; all outputs 0; a new start restarts at addr 0 and the first word written equals the first two new bytes.
- start pulsed while in LO -> ignored, and the word completes at the expected address; start in DONE -> done clears and the new session writes from addr 0.
- rx_valid pulses in IDLE before start -> no writes and rx_ready stays 0; after start the first accepted byte is the first one presented in HI.
